// File: rtl/alu_result_collector.sv
// ALU result collector: captures one flagged unit result per cycle by fixed priority, queues it
// with its unit ID and presents it over valid/ready. Optional RESULT_PARITY_EN adds out_parity.
module alu_result_collector #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         arith_out,
    input  logic                          arith_flag,
    input  logic [DATA_WIDTH-1:0]         logic_out,
    input  logic                          logic_flag,
    input  logic [DATA_WIDTH-1:0]         cmp_out,
    input  logic                          cmp_flag,
    input  logic [DATA_WIDTH-1:0]         shift_out,
    input  logic                          shift_flag,
    input  logic                          out_ready,
    input  logic                          err_clr,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [1:0]                    out_unit,
`ifdef RESULT_PARITY_EN
    output logic                          out_parity,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow_err,
    output logic                          multi_flag_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
`ifdef RESULT_PARITY_EN
    localparam int unsigned EW = DATA_WIDTH + 3;
`else
    localparam int unsigned EW = DATA_WIDTH + 2;
`endif

    typedef enum logic [1:0] {
        UnitArith = 2'b00,
        UnitLogic = 2'b01,
        UnitCmp   = 2'b10,
        UnitShift = 2'b11
    } unit_e;

    logic [EW-1:0]         r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_count;
    logic                  r_overflow_err;
    logic                  r_multi_flag_err;

    logic                  w_wr_req;
    logic                  w_multi;
    unit_e                 w_sel_unit;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [EW-1:0]         w_entry;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_ovf_evt;
    logic [PW-1:0]         w_wr_ptr_d;
    logic [PW-1:0]         w_rd_ptr_d;
    logic [PW-1:0]         w_count_d;
    logic                  w_overflow_err_d;
    logic                  w_multi_flag_err_d;
    logic [EW-1:0]         w_head;

    // Fixed priority: arith > logic > cmp > shift; lower-priority results are discarded.
    always_comb begin
        w_sel_unit = UnitArith;
        w_sel_data = arith_out;
        if (arith_flag) begin
            w_sel_unit = UnitArith;
            w_sel_data = arith_out;
        end else if (logic_flag) begin
            w_sel_unit = UnitLogic;
            w_sel_data = logic_out;
        end else if (cmp_flag) begin
            w_sel_unit = UnitCmp;
            w_sel_data = cmp_out;
        end else if (shift_flag) begin
            w_sel_unit = UnitShift;
            w_sel_data = shift_out;
        end
    end

    always_comb begin
        w_wr_req = arith_flag | logic_flag | cmp_flag | shift_flag;
        w_multi  = (arith_flag & logic_flag) | (arith_flag & cmp_flag) |
                   (arith_flag & shift_flag) | (logic_flag & cmp_flag) |
                   (logic_flag & shift_flag) | (cmp_flag & shift_flag);
`ifdef RESULT_PARITY_EN
        w_entry  = {^{w_sel_unit, w_sel_data}, w_sel_unit, w_sel_data};
`else
        w_entry  = {w_sel_unit, w_sel_data};
`endif
    end

    // A full FIFO still accepts a write when the head is read in the same cycle.
    always_comb begin
        w_full     = (r_count == PW'(FIFO_DEPTH));
        w_empty    = (r_count == '0);
        w_rd       = !w_empty && out_ready;
        w_wr       = w_wr_req && (!w_full || w_rd);
        w_ovf_evt  = w_wr_req && w_full && !w_rd;
        w_wr_ptr_d = r_wr_ptr + PW'(w_wr);
        w_rd_ptr_d = r_rd_ptr + PW'(w_rd);
        w_count_d  = w_wr_ptr_d - w_rd_ptr_d;
    end

    // A new error in the same cycle as err_clr wins over the clear.
    always_comb begin
        w_overflow_err_d   = (r_overflow_err & ~err_clr) | w_ovf_evt;
        w_multi_flag_err_d = (r_multi_flag_err & ~err_clr) | w_multi;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_overflow_err   <= 1'b0;
            r_multi_flag_err <= 1'b0;
        end else begin
            r_wr_ptr         <= w_wr_ptr_d;
            r_rd_ptr         <= w_rd_ptr_d;
            r_count          <= w_count_d;
            r_overflow_err   <= w_overflow_err_d;
            r_multi_flag_err <= w_multi_flag_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
        end
    end

    // Head fields are masked while empty so reset and idle present all-zero outputs.
    always_comb begin
        w_head         = r_mem[r_rd_ptr[AW-1:0]];
        out_valid      = !w_empty;
        out_data       = out_valid ? w_head[DATA_WIDTH-1:0] : '0;
        out_unit       = out_valid ? w_head[DATA_WIDTH+1:DATA_WIDTH] : 2'b00;
`ifdef RESULT_PARITY_EN
        out_parity     = out_valid ? w_head[DATA_WIDTH+2] : 1'b0;
`endif
        fifo_count     = r_count;
        overflow_err   = r_overflow_err;
        multi_flag_err = r_multi_flag_err;
    end

endmodule

// File: tb/tb_alu_result_collector.sv
// Self-checking bench for alu_result_collector: directed vector table, hand sequences for
// streaming and async reset, then randomized traffic against a queue-based reference model.
module tb_alu_result_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] arith_out, logic_out, cmp_out, shift_out;
    logic        arith_flag, logic_flag, cmp_flag, shift_flag;
    logic        out_ready, err_clr;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_unit;
    logic [2:0]  fifo_count;
    logic        overflow_err, multi_flag_err;
`ifdef RESULT_PARITY_EN
    logic        out_parity;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    alu_result_collector #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .arith_out      (arith_out),
        .arith_flag     (arith_flag),
        .logic_out      (logic_out),
        .logic_flag     (logic_flag),
        .cmp_out        (cmp_out),
        .cmp_flag       (cmp_flag),
        .shift_out      (shift_out),
        .shift_flag     (shift_flag),
        .out_ready      (out_ready),
        .err_clr        (err_clr),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_unit       (out_unit),
`ifdef RESULT_PARITY_EN
        .out_parity     (out_parity),
`endif
        .fifo_count     (fifo_count),
        .overflow_err   (overflow_err),
        .multi_flag_err (multi_flag_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  flg;   // {arith, logic, cmp, shift}
        logic [15:0] da, dl, dc, ds;
        logic        rdy, clr;
        logic        ev;
        logic [15:0] ed;
        logic [1:0]  eu;
        logic [2:0]  ec;
        logic        eo, em;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic [3:0] f, input logic [15:0] da, input logic [15:0] dl,
                         input logic [15:0] dc, input logic [15:0] ds, input logic rdy,
                         input logic clr);
        {arith_flag, logic_flag, cmp_flag, shift_flag} = f;
        arith_out = da; logic_out = dl; cmp_out = dc; shift_out = ds;
        out_ready = rdy; err_clr = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] f, input logic [15:0] da,
                                input logic [15:0] dl, input logic [15:0] dc,
                                input logic [15:0] ds, input logic rdy, input logic clr,
                                input logic ev, input logic [15:0] ed, input logic [1:0] eu,
                                input logic [2:0] ec, input logic eo, input logic em);
        vec_t v;
        v.flg = f; v.da = da; v.dl = dl; v.dc = dc; v.ds = ds; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ed = ed; v.eu = eu; v.ec = ec; v.eo = eo; v.em = em;
        return v;
    endfunction

    task automatic chk_head(input string tag, input logic ev, input logic [15:0] ed,
                            input logic [1:0] eu, input logic [2:0] ec, input logic eo,
                            input logic em);
        chk({tag, "_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, "_count"}, 32'(fifo_count), 32'(ec));
        chk({tag, "_ovf"}, 32'(overflow_err), 32'(eo));
        chk({tag, "_mfe"}, 32'(multi_flag_err), 32'(em));
        if (ev) begin
            chk({tag, "_data"}, 32'(out_data), 32'(ed));
            chk({tag, "_unit"}, 32'(out_unit), 32'(eu));
`ifdef RESULT_PARITY_EN
            chk({tag, "_par"}, 32'(out_parity), 32'(^{eu, ed}));
`endif
        end
    endtask

    // Reference model: a plain queue of {unit, data} plus two sticky bits.
    logic [17:0] mq[$];
    logic        m_ovf, m_mfe;

    task automatic model_cycle(input logic [3:0] f, input logic [15:0] da,
                               input logic [15:0] dl, input logic [15:0] dc,
                               input logic [15:0] ds, input logic rdy, input logic clr);
        logic        rd, full;
        logic [17:0] ent;
        rd   = (mq.size() > 0) && rdy;
        full = (mq.size() == 4);
        if (f[3])      ent = {2'd0, da};
        else if (f[2]) ent = {2'd1, dl};
        else if (f[1]) ent = {2'd2, dc};
        else           ent = {2'd3, ds};
        if (rd) void'(mq.pop_front());
        if (f != 4'b0 && !(full && !rd)) mq.push_back(ent);
        m_ovf = (m_ovf & ~clr) | (f != 4'b0 && full && !rd);
        m_mfe = (m_mfe & ~clr) | ($countones(f) >= 2);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        m_mfe = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        drive(4'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        #3;
        chk_head("reset", 1'b0, 16'h0, 2'd0, 3'd0, 1'b0, 1'b0);
        chk("reset_data", 32'(out_data), 32'h0);
        chk("reset_unit", 32'(out_unit), 32'h0);
`ifdef RESULT_PARITY_EN
        chk("reset_par", 32'(out_parity), 32'h0);
`endif
        #9 rst = 1'b1;

        // flags, da, dl, dc, ds, rdy, clr, exp: valid, data, unit, count, ovf, mfe
        vt.push_back(mk(4'b0010, 0, 0, 16'h0003, 0, 0, 0, 1, 16'h0003, 2, 1, 0, 0));
        vt.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 4; i++)
            vt.push_back(mk(4'b1000, 16'(i), 0, 0, 0, 0, 0, 1, 16'h1, 0, 3'(i), 0, 0));
        vt.push_back(mk(4'b1000, 16'h5, 0, 0, 0, 0, 0, 1, 16'h1, 0, 4, 1, 0));
        vt.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 1, 16'h2, 0, 3, 1, 0));
        vt.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 1, 16'h3, 0, 2, 1, 0));
        vt.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 1, 16'h4, 0, 1, 1, 0));
        vt.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 4; i++)
            vt.push_back(mk(4'b1000, 16'(i), 0, 0, 0, 0, 0, 1, 16'h1, 0, 3'(i), 0, 0));
        vt.push_back(mk(4'b0100, 0, 16'h00AA, 0, 0, 1, 0, 1, 16'h2, 0, 4, 0, 0));
        vt.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 1, 16'h3, 0, 3, 0, 0));
        vt.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 1, 16'h4, 0, 2, 0, 0));
        vt.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 1, 16'h00AA, 1, 1, 0, 0));
        vt.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(4'b1001, 16'h1111, 0, 0, 16'h2222, 0, 0, 1, 16'h1111, 0, 1, 0, 1));
        vt.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 1, 16'h1111, 0, 1, 0, 0));
        vt.push_back(mk(4'b0011, 0, 0, 16'h0C0C, 16'h5, 1, 1, 1, 16'h0C0C, 2, 1, 0, 1));
        vt.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));

        foreach (vt[i]) begin
            drive(vt[i].flg, vt[i].da, vt[i].dl, vt[i].dc, vt[i].ds, vt[i].rdy, vt[i].clr);
            step();
            chk_head($sformatf("vec%0d", i), vt[i].ev, vt[i].ed, vt[i].eu, vt[i].ec,
                     vt[i].eo, vt[i].em);
        end

        // Streaming through the pointer wrap: one in, one out every cycle.
        drive(4'b0, 0, 0, 0, 0, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 20; i++) begin
            drive(4'b0100, 0, 16'(i), 0, 0, 1'b1, 1'b0);
            step();
            chk($sformatf("stream%0d_data", i), 32'(out_data), 32'(i));
            chk($sformatf("stream%0d_valid", i), 32'(out_valid), 32'h1);
            chk($sformatf("stream%0d_cnt_le1", i), 32'(fifo_count <= 3'd1), 32'h1);
        end
        drive(4'b0, 0, 0, 0, 0, 1'b1, 1'b0);
        step();
        chk_head("stream_end", 1'b0, 0, 0, 3'd0, 1'b0, 1'b0);

        // Async reset mid-stream: takes effect between edges.
        for (int i = 0; i < 3; i++) begin
            drive(4'b0010, 0, 0, 16'(16'h100 + i), 0, 1'b0, 1'b0);
            step();
        end
        chk("pre_rst_count", 32'(fifo_count), 32'd3);
        drive(4'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_count", 32'(fifo_count), 32'h0);
        #2 rst = 1'b1;
        drive(4'b0001, 0, 0, 0, 16'h7777, 1'b0, 1'b0);
        step();
        chk_head("post_rst", 1'b1, 16'h7777, 2'd3, 3'd1, 1'b0, 1'b0);

        // Randomized traffic against the model.
        drive(4'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [3:0]  f;
            logic [15:0] da, dl, dc, ds;
            logic        rdy, clr;
            for (int b = 0; b < 4; b++) f[b] = ($urandom_range(0, 99) < 30);
            da = 16'($urandom); dl = 16'($urandom); dc = 16'($urandom); ds = 16'($urandom);
            rdy = ($urandom_range(0, 99) < 45);
            clr = ($urandom_range(0, 99) < 8);
            drive(f, da, dl, dc, ds, rdy, clr);
            model_cycle(f, da, dl, dc, ds, rdy, clr);
            step();
            if (mq.size() > 0)
                chk_head($sformatf("rnd%0d", c), 1'b1, mq[0][15:0], mq[0][17:16],
                         3'(mq.size()), m_ovf, m_mfe);
            else
                chk_head($sformatf("rnd%0d", c), 1'b0, 16'h0, 2'd0, 3'd0, m_ovf, m_mfe);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
